// File: rtl/spray_pkg.sv
// Shared definitions for the spray controller and its interval timer.
package spray_pkg;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} timer_state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PRESCALE = 10;
  localparam int unsigned DEF_DURATION = 5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into time-unit ticks; tick is high on the last cycle of each unit.
module tick_prescaler
  import spray_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spray_timer.sv
// Programmable interval timer: runs for a number of prescaled units after clrt,
// then holds tdone until the next clrt.
module spray_timer
  import spray_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned DURATION = DEF_DURATION
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clrt,
  input  logic             dur_load,
  input  logic [WIDTH-1:0] dur_in,
  output logic             tdone,
  output logic             busy,
  output logic [WIDTH-1:0] elapsed
);

  timer_state_t     state, state_nxt;
  logic [WIDTH-1:0] dur_q;
  logic [WIDTH-1:0] dur_eff;
  logic             tick;
  logic             last_unit;
  logic             load_ok;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clrt),
    .en    (state == T_RUN),
    .tick  (tick)
  );

  assign dur_eff   = dur_load ? dur_in : dur_q;
  assign last_unit = tick && (elapsed == dur_q - 1'b1);
  // A load paired with clrt must govern the new run, so it is taken even when
  // the restart happens from T_RUN; otherwise loads are held off while running.
  assign load_ok   = dur_load && ((state != T_RUN) || clrt);

  always_comb begin
    state_nxt = state;
    if (clrt) begin
      state_nxt = (dur_eff == '0) ? T_DONE : T_RUN;
    end else if (state == T_RUN && last_unit) begin
      state_nxt = T_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= T_IDLE;
      dur_q   <= WIDTH'(DURATION);
      elapsed <= '0;
    end else begin
      state <= state_nxt;
      if (load_ok) begin
        dur_q <= dur_in;
      end
      if (clrt) begin
        elapsed <= '0;
      end else if (state == T_RUN && tick) begin
        elapsed <= elapsed + 1'b1;
      end
    end
  end

  assign tdone = (state == T_DONE);
  assign busy  = (state == T_RUN);

endmodule

// File: tb/tb_spray_timer.sv
// Self-checking bench for spray_timer with PRESCALE=2, DURATION=3, WIDTH=8.
module tb_spray_timer;

  logic       clk;
  logic       reset;
  logic       clrt;
  logic       dur_load;
  logic [7:0] dur_in;
  logic       tdone;
  logic       busy;
  logic [7:0] elapsed;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic       clrt;
    logic       load;
    logic [7:0] din;
    logic       t;
    logic       b;
    logic [7:0] e;
  } vec_t;

  typedef struct {
    string      name;
    logic       t;
    logic       b;
    logic [7:0] e;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  spray_timer #(.WIDTH(8), .PRESCALE(2), .DURATION(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .clrt     (clrt),
    .dur_load (dur_load),
    .dur_in   (dur_in),
    .tdone    (tdone),
    .busy     (busy),
    .elapsed  (elapsed)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_front();
    exp_t x;
    x = sb.pop_front();
    compared++;
    if ({tdone, busy, elapsed} !== {x.t, x.b, x.e}) begin
      mismatched++;
      $display("FAIL %s: got tdone=%0b busy=%0b elapsed=%0d, want tdone=%0b busy=%0b elapsed=%0d",
               x.name, tdone, busy, elapsed, x.t, x.b, x.e);
    end
  endtask

  task automatic check_now(input string nm, input logic t, input logic b, input logic [7:0] e);
    sb.push_back('{nm, t, b, e});
    check_front();
  endtask

  task automatic add(input string nm, input logic c, input logic l, input logic [7:0] d,
                     input logic t, input logic b, input logic [7:0] e);
    tbl.push_back('{nm, c, l, d, t, b, e});
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      @(negedge clk);
      clrt     = tbl[i].clrt;
      dur_load = tbl[i].load;
      dur_in   = tbl[i].din;
      sb.push_back('{tbl[i].name, tbl[i].t, tbl[i].b, tbl[i].e});
      @(posedge clk);
      #1;
      check_front();
    end
    @(negedge clk);
    clrt     = 1'b0;
    dur_load = 1'b0;
    dur_in   = '0;
    tbl.delete();
  endtask

  task automatic add_idle(input string nm, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(nm, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  // Spray FSM model: token -> clrt pulse, spray while waiting for tdone.
  task automatic spray_loop();
    int spray_cycles;
    int budget;
    @(negedge clk);
    clrt = 1'b1;
    @(negedge clk);
    clrt = 1'b0;
    spray_cycles = 1;
    budget = 50;
    while (!tdone && budget > 0) begin
      @(negedge clk);
      if (!tdone) spray_cycles++;
      budget--;
    end
    compared++;
    if (budget == 0 || spray_cycles != 6) begin
      mismatched++;
      $display("FAIL spray_len: got %0d cycles (budget left %0d), want 6", spray_cycles, budget);
    end
    check_now("fsm_back_idle", 1'b1, 1'b0, 8'd3);
  endtask

  initial begin
    reset    = 1'b0;
    clrt     = 1'b0;
    dur_load = 1'b0;
    dur_in   = '0;

    // 1: reset state, then quiet for 20 cycles
    #15 reset = 1'b1;
    #1 check_now("reset_state", 1'b0, 1'b0, 8'd0);
    add_idle("idle_hold", 20);
    run_table();

    // 2: single run of D=3 units, 6 cycles
    add("run_e0",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("run_e1",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("run_e2",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("run_e3",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("run_e4",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("run_e5",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("run_done", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
    add("run_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
    add("run_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
    run_table();

    // 3: restart during run (also leaves T_DONE on clrt)
    add("rst_e0",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("rst_e1",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("rst_e2",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("rst_e3",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("rst_e4",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("rst_e5",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("rst_e6",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("rst_e7",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("rst_e8",   1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("rst_done", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
    run_table();

    // 4: load ignored while running, accepted in T_DONE
    add("ld_e0",    1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("ld_run",   1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 8'd0);
    add("ld_e2",    1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("ld_e3",    1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    add("ld_e4",    1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("ld_e5",    1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2);
    add("ld_done3", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
    add("ld_indone",1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 8'd3);
    add("ld5_e0",   1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    for (int unsigned k = 1; k < 10; k++)
      add("ld5_run", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'(k / 2));
    add("ld5_done", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5);
    add("ld5_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5);
    run_table();

    // 5: zero duration loaded with clrt from T_IDLE
    reset = 1'b0;
    #1 check_now("async_rst_done", 1'b0, 1'b0, 8'd0);
    #4 reset = 1'b1;
    add("zero_e0",   1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0);
    add("zero_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    add("zero_hold", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    add("zero_rerun",1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
    run_table();

    // 6: asynchronous reset in mid-run
    add("ab_e0", 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 8'd0);
    add("ab_e1", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
    add("ab_e2", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1);
    run_table();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_now("abort_now", 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    add_idle("abort_quiet", 20);
    run_table();

    // spray FSM loop with restored reset duration of 3 units
    spray_loop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
